// File: rtl/score_text_rom.sv
// rtl/score_text_rom.sv - BCD score store, 16x16 score-screen char lookup and leader scan
// Optional LEADER_MARK_EN: mark the current leader's row with '*' in the padding columns.
module score_text_rom #(
   parameter int N_PLAYERS = 3,
   parameter int DIGITS    = 6,
   parameter int ID_W      = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      char_xy,
   input  logic            char_req,
   input  logic [ID_W-1:0] board_id,
   input  logic [23:0]     local_points,
   input  logic            local_vld,
   input  logic [31:0]     ext_data_1,
   input  logic            ext_vld_1,
   input  logic [31:0]     ext_data_2,
   input  logic            ext_vld_2,
   input  logic            clear,
   output logic [6:0]      char_code,
   output logic            char_vld,
   output logic [ID_W-1:0] leader_id,
   output logic            bad_write
);
   localparam int SW = 4 * DIGITS;
   localparam logic [127:0] ROW0    = ">>>>>SCORE:<<<<<";
   localparam logic [47:0]  PLAYER  = "Player";
   localparam logic [111:0] YOU_ARE = "You are Player";

   typedef enum logic {IDLE, SCAN} state_t;

   function automatic logic digits_ok(input logic [23:0] v);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < DIGITS; k++)
         if (v[4*k +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic id_ok(input logic [ID_W-1:0] id);
      return (id != '0) && (int'(id) <= N_PLAYERS);
   endfunction

   logic [SW-1:0]   r_score [N_PLAYERS];
   state_t          r_state;
   logic [3:0]      r_idx;
   logic [SW-1:0]   r_best;
   logic [ID_W-1:0] r_best_id;
   logic            r_pend;

   logic [ID_W-1:0] w_e1_id, w_e2_id;
   logic            w_loc_ok, w_e1_ok, w_e2_ok, w_bad, w_any;
   logic [SW-1:0]   w_row_score, w_cur;
   logic            w_gt;
   logic [3:0]      w_row, w_col, w_digit;
   logic [6:0]      w_code;

   assign w_e1_id  = ID_W'(ext_data_1[27:24]);
   assign w_e2_id  = ID_W'(ext_data_2[27:24]);
   assign w_loc_ok = local_vld && id_ok(board_id) && digits_ok(local_points);
   assign w_e1_ok  = ext_vld_1 && id_ok(w_e1_id) && digits_ok(ext_data_1[23:0]);
   assign w_e2_ok  = ext_vld_2 && id_ok(w_e2_id) && digits_ok(ext_data_2[23:0]);
   assign w_bad    = (local_vld && !w_loc_ok) || (ext_vld_1 && !w_e1_ok) || (ext_vld_2 && !w_e2_ok);
   assign w_any    = w_loc_ok || w_e1_ok || w_e2_ok || clear;

   // Per-player priority chain: same-id losers fall through silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_PLAYERS; i++) r_score[i] <= '0;
         bad_write <= 1'b0;
      end else begin
         bad_write <= w_bad;
         for (int i = 0; i < N_PLAYERS; i++) begin
            if (clear)                              r_score[i] <= '0;
            else if (w_loc_ok && int'(board_id) == i + 1) r_score[i] <= local_points[SW-1:0];
            else if (w_e1_ok && int'(w_e1_id) == i + 1)   r_score[i] <= ext_data_1[SW-1:0];
            else if (w_e2_ok && int'(w_e2_id) == i + 1)   r_score[i] <= ext_data_2[SW-1:0];
         end
      end
   end

   assign w_row = char_xy[7:4];
   assign w_col = char_xy[3:0];

   always_comb begin
      w_row_score = '0;
      w_cur       = '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
         if (int'(w_row) == i + 1) w_row_score = r_score[i];
         if (int'(r_idx) == i + 1) w_cur = r_score[i];
      end
   end

   assign w_gt = w_cur > r_best;

   always_comb begin
      w_code  = 7'h20;
      w_digit = '0;
      if (w_row == 4'd0) begin
         w_code = ROW0[8*(15-int'(w_col)) +: 7];
      end else if (int'(w_row) <= N_PLAYERS) begin
         if (w_col <= 4'd5)      w_code = PLAYER[8*(5-int'(w_col)) +: 7];
         else if (w_col == 4'd6) w_code = 7'h30 | {3'b000, w_row};
         else if (w_col == 4'd7) w_code = 7'h3A;
         else if (int'(w_col) >= 16 - DIGITS) begin
            for (int k = 0; k < DIGITS; k++)
               if (int'(w_col) == 15 - k) w_digit = w_row_score[4*k +: 4];
            w_code = 7'h30 | {3'b000, w_digit};
         end
`ifdef LEADER_MARK_EN
         else if (leader_id != '0 && int'(leader_id) == int'(w_row)) w_code = 7'h2A;
`endif
      end else if (int'(w_row) == N_PLAYERS + 2) begin
         if (w_col <= 4'd13)      w_code = YOU_ARE[8*(13-int'(w_col)) +: 7];
         else if (w_col == 4'd14) w_code = (board_id == '0 || int'(board_id) > 9) ? 7'h3F
                                          : (7'h30 | {3'b000, board_id[3:0]});
         else                     w_code = 7'h21;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_code <= 7'h20;
         char_vld  <= 1'b0;
      end else begin
         char_vld <= char_req;
         if (char_req) char_code <= w_code;
      end
   end

   // Leader scan: one player per cycle; leader_id only moves at scan end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_idx     <= 4'd1;
         r_best    <= '0;
         r_best_id <= '0;
         r_pend    <= 1'b0;
         leader_id <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state   <= SCAN;
                  r_idx     <= 4'd1;
                  r_best    <= '0;
                  r_best_id <= '0;
                  r_pend    <= 1'b0;
               end
            end
            SCAN: begin
               if (w_gt) begin
                  r_best    <= w_cur;
                  r_best_id <= ID_W'(r_idx);
               end
               if (int'(r_idx) == N_PLAYERS) begin
                  leader_id <= w_gt ? ID_W'(r_idx) : r_best_id;
                  if (r_pend || w_any) begin
                     r_idx     <= 4'd1;
                     r_best    <= '0;
                     r_best_id <= '0;
                     r_pend    <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_idx <= r_idx + 4'd1;
                  if (w_any) r_pend <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_score_text_rom.sv
// tb/tb_score_text_rom.sv - randomized self-checking bench for score_text_rom against a string-level model
module tb_score_text_rom;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  char_xy;
   logic        char_req;
   logic [3:0]  board_id;
   logic [23:0] local_points;
   logic        local_vld;
   logic [31:0] ext_data_1;
   logic        ext_vld_1;
   logic [31:0] ext_data_2;
   logic        ext_vld_2;
   logic        clear;
   logic [6:0]  char_code;
   logic        char_vld;
   logic [3:0]  leader_id;
   logic        bad_write;

   int n_cmp = 0;
   int n_mis = 0;

   logic [23:0] m_score [1:3];
   int          m_leader;

   score_text_rom #(.N_PLAYERS(3), .DIGITS(6), .ID_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .char_xy(char_xy), .char_req(char_req),
      .board_id(board_id), .local_points(local_points), .local_vld(local_vld),
      .ext_data_1(ext_data_1), .ext_vld_1(ext_vld_1),
      .ext_data_2(ext_data_2), .ext_vld_2(ext_vld_2), .clear(clear),
      .char_code(char_code), .char_vld(char_vld),
      .leader_id(leader_id), .bad_write(bad_write)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit bcd_ok(input logic [23:0] v);
      string s;
      s = $sformatf("%06h", v);
      for (int i = 0; i < 6; i++)
         if (s[i] < "0" || s[i] > "9") return 1'b0;
      return 1'b1;
   endfunction

   function automatic int best_player();
      logic [23:0] best;
      int id;
      best = 0;
      id = 0;
      for (int i = 1; i <= 3; i++)
         if (m_score[i] > best) begin best = m_score[i]; id = i; end
      return id;
   endfunction

   function automatic logic [6:0] exp_char(input int r, input int c);
      string s;
      byte   b;
      bit    mark;
      mark = 1'b0;
`ifdef LEADER_MARK_EN
      mark = (m_leader == r);
`endif
      if (r == 0)
         s = ">>>>>SCORE:<<<<<";
      else if (r >= 1 && r <= 3)
         s = $sformatf("Player%0d:%s%06h", r, mark ? "**" : "  ", m_score[r]);
      else if (r == 5)
         s = $sformatf("You are Player%s!",
                       (board_id == 0 || board_id > 9) ? "?" : $sformatf("%0d", board_id));
      else
         return 7'h20;
      b = s[c];
      return b[6:0];
   endfunction

   // Apply strobed writes in priority order; returns whether any was rejected.
   function automatic bit model_apply();
      bit taken [1:4];
      bit bad;
      int ids [3];
      logic [23:0] vals [3];
      bit vlds [3];
      bad = 0;
      for (int i = 1; i <= 4; i++) taken[i] = 0;
      ids[0] = int'(board_id);          vals[0] = local_points;       vlds[0] = local_vld;
      ids[1] = int'(ext_data_1[27:24]); vals[1] = ext_data_1[23:0];   vlds[1] = ext_vld_1;
      ids[2] = int'(ext_data_2[27:24]); vals[2] = ext_data_2[23:0];   vlds[2] = ext_vld_2;
      for (int w = 0; w < 3; w++) begin
         if (vlds[w]) begin
            if (ids[w] >= 1 && ids[w] <= 3 && bcd_ok(vals[w])) begin
               if (!taken[ids[w]]) begin
                  taken[ids[w]] = 1;
                  if (!clear) m_score[ids[w]] = vals[w];
               end
            end else begin
               bad = 1;
            end
         end
      end
      if (clear) for (int i = 1; i <= 3; i++) m_score[i] = 0;
      return bad;
   endfunction

   task automatic step();
      logic [6:0] ec;
      bit eb;
      bit req;
      req = char_req;
      ec = exp_char(int'(char_xy[7:4]), int'(char_xy[3:0]));
      eb = model_apply();
      tick();
      check("bad_write", bad_write, eb);
      check("char_vld", char_vld, req);
      if (req) check($sformatf("char_%02h", char_xy), char_code, ec);
      local_vld = 0; ext_vld_1 = 0; ext_vld_2 = 0; clear = 0; char_req = 0;
   endtask

   task automatic look(input int r, input int c);
      char_xy = {4'(r), 4'(c)};
      char_req = 1;
      step();
   endtask

   task automatic settle();
      repeat (8) tick();
      m_leader = best_player();
      check("leader", leader_id, m_leader);
   endtask

   function automatic logic [23:0] rnd_score();
      logic [23:0] v;
      for (int k = 0; k < 6; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) v[23:12] = 0;
      if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
      return v;
   endfunction

   function automatic logic [31:0] ext_word(input int id, input logic [23:0] v);
      return {4'($urandom_range(0, 15)), 4'(id), v};
   endfunction

   initial begin
      rst_n = 0; char_xy = 0; char_req = 0; board_id = 1; local_points = 0; local_vld = 0;
      ext_data_1 = 0; ext_vld_1 = 0; ext_data_2 = 0; ext_vld_2 = 0; clear = 0;
      for (int i = 1; i <= 3; i++) m_score[i] = 0;
      m_leader = 0;
      repeat (3) tick();
      check("rst_code", char_code, 7'h20);
      check("rst_vld", char_vld, 0);
      check("rst_leader", leader_id, 0);
      check("rst_bad", bad_write, 0);
      rst_n = 1;
      tick();
      look(1, 15);
      check("first_digit", char_code, 7'h30);

      // local write and leader latency
      board_id = 1; local_points = 24'h001234; local_vld = 1;
      step();
      tick(); check("lead_lat1", leader_id, 0);
      tick(); check("lead_lat2", leader_id, 0);
      tick(); check("lead_lat3", leader_id, 1);
      m_leader = 1;
      for (int c = 12; c <= 15; c++) look(1, c);
      check("digit_4", char_code, 7'h34);

      // same id on both links: ext_1 wins
      ext_data_1 = ext_word(2, 24'h005000); ext_vld_1 = 1;
      ext_data_2 = ext_word(2, 24'h000007); ext_vld_2 = 1;
      step();
      settle();
      for (int c = 10; c <= 15; c++) look(2, c);

      // rejected writes
      ext_data_1 = ext_word(4, 24'h000100); ext_vld_1 = 1; step();
      ext_data_1 = ext_word(1, 24'h00000A); ext_vld_1 = 1; step();
      tick(); tick(); tick();
      check("no_scan", leader_id, 2);

      // write during active scan triggers rescan
      ext_data_1 = ext_word(1, 24'h000001); ext_vld_1 = 1; step();
      ext_data_2 = ext_word(3, 24'h009999); ext_vld_2 = 1; step();
      settle();
      look(3, 8); look(3, 9); look(2, 8);
      clear = 1; step();
      settle();

      // local > ext_1 > ext_2 on the same id, and write+lookup sees old data
      board_id = 1; local_points = 24'h000111; local_vld = 1;
      ext_data_1 = ext_word(1, 24'h000222); ext_vld_1 = 1;
      ext_data_2 = ext_word(1, 24'h000333); ext_vld_2 = 1;
      char_xy = 8'h1F; char_req = 1;
      step();
      look(1, 15);
      settle();

      board_id = 2; look(5, 14);
      check("you_id", char_code, 7'h32);
      board_id = 0;  look(5, 14);
      board_id = 12; look(5, 14);
      look(5, 15); look(4, 3); look(0, 5); look(6, 0);
      board_id = 1;

      // randomized traffic
      for (int it = 0; it < 60; it++) begin
         board_id = 4'($urandom_range(0, 4));
         local_points = rnd_score(); local_vld = $urandom_range(0, 1);
         ext_data_1 = ext_word($urandom_range(0, 4), rnd_score()); ext_vld_1 = $urandom_range(0, 1);
         ext_data_2 = ext_word($urandom_range(0, 4), rnd_score()); ext_vld_2 = $urandom_range(0, 1);
         clear = ($urandom_range(0, 9) == 0);
         char_req = $urandom_range(0, 1);
         char_xy = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 15))};
         step();
         if ($urandom_range(0, 2) == 0) begin
            ext_data_1 = ext_word($urandom_range(1, 3), rnd_score()); ext_vld_1 = 1;
            step();
         end
         settle();
         for (int k = 0; k < 4; k++) look($urandom_range(0, 7), $urandom_range(0, 15));
      end

      // reset in the middle of a scan with a lookup pending
      board_id = 2; local_points = 24'h000500; local_vld = 1;
      char_xy = 8'h2F; char_req = 1;
      step();
      char_req = 1;
      tick();
      rst_n = 0;
      #1;
      check("mid_rst_vld", char_vld, 0);
      check("mid_rst_code", char_code, 7'h20);
      check("mid_rst_leader", leader_id, 0);
      check("mid_rst_bad", bad_write, 0);
      char_req = 0;
      for (int i = 1; i <= 3; i++) m_score[i] = 0;
      tick();
      rst_n = 1;
      settle();
      look(2, 13); look(1, 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/score_text_rom.md
Name: score_text_rom

Overview:
- Parametrised, registered successor to the 16x16 score-screen character ROM.
- Stores BCD scores for up to N_PLAYERS players in flip-flops and accepts validated updates from the local board and two external links.
- Serves a char_code per 16x16 text-grid cell with fixed 1-cycle latency.
- Tracks the current leader with a sequential scan. It sits between the board/UART data path and the font ROM/text-draw pipeline.

Parameters:
- N_PLAYERS, 3, number of player rows and score registers; legal range 1..9.
- DIGITS, 6, BCD digits per score; legal range 1..6, right-aligned in cols 16-DIGITS..15.
- ID_W, 4, player-id field width in ext words and on id ports.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- char_xy  in  8  cell address, [7:4]=row, [3:0]=col
- char_req  in  1  lookup request for char_xy
- board_id  in  ID_W  this board's player number
- local_points  in  24  local score, six packed BCD digits, MSD at [23:20]
- local_vld  in  1  one-cycle strobe: write local_points to board_id
- ext_data_1  in  32  external word: [27:24]=player id, [23:0]=BCD score, [31:28] ignored
- ext_vld_1  in  1  strobe for ext_data_1
- ext_data_2  in  32  same format as ext_data_1
- ext_vld_2  in  1  strobe for ext_data_2
- clear  in  1  synchronous: zero all scores
- char_code  out  7  ASCII code for requested cell
- char_vld  out  1  char_code valid, one cycle after char_req
- leader_id  out  ID_W  player with the highest score; 0 = no leader (all scores zero)
- bad_write  out  1  one-cycle pulse: a strobed write was rejected

Behaviour:
- Reset: all score registers 0, char_code=7'h20, char_vld=0, leader_id=0, bad_write=0, FSM=IDLE.
- Score writes:
  - A strobed write is accepted only if id is in 1..N_PLAYERS and the low DIGITS nibbles are all <=9.
  - Otherwise the score registers are unchanged and bad_write pulses the next cycle.
  - Only the low 4*DIGITS bits of the 24-bit score are stored.
- Simultaneous writes:
  - Different ids: all are applied in the same cycle.
  - Same id: priority is local > ext_1 > ext_2. Losing writes are dropped silently, with no bad_write.
- clear: overrides all writes that cycle and schedules a rescan.
- Lookup:
  - char_code and char_vld are registered on the clock edge after char_req, giving 1-cycle latency.
  - With char_req=0, char_vld goes to 0 and char_code holds its value.
  - A score write and a lookup of that score in the same cycle return the old value; new data is visible from the next request.
- Grid layout (row r, col c):
  - Row 0: ">>>>>SCORE:<<<<<".
  - Rows 1..N_PLAYERS: "Player" + ('0'+r) + ":" in cols 0..7. Cols 8..15-DIGITS are spaces. Score digits go in cols 16-DIGITS..15 as 7'h30|digit, MSD first.
  - Row N_PLAYERS+2: "You are Player" + ('0'+board_id[3:0]) + "!"; if board_id is 0 or >9, col 14 is '?'.
  - All other cells: 7'h20.
- Leader FSM, states IDLE and SCAN:
  - IDLE -> SCAN on any accepted write or clear. The scan index is set to 1; best=0, best_id=0.
  - SCAN visits one player per cycle. If score[i] > best (packed BCD compared as unsigned), it takes best=score[i], best_id=i. Ties keep the lower id; a zero score never becomes leader.
  - After player N_PLAYERS, leader_id<=best_id and the FSM returns to IDLE. A scan therefore takes N_PLAYERS cycles.
  - An accepted write or clear during SCAN sets rescan_pend. At scan end the FSM goes straight back to SCAN and leader_id is still updated. leader_id changes only at scan end.
- Mid-operation reset: rst_n low forces all reset values immediately, regardless of FSM state or pending lookup.

Optional Feature:
- Macro LEADER_MARK_EN.
- Defined: on the row of the current leader_id (non-zero), cols 8..15-DIGITS show '*' (7'h2A) instead of spaces. With DIGITS=6, the marked columns are 8..9. The mark follows leader_id with the same 1-cycle lookup latency.
- Undefined: those columns are always spaces and leader_id has no effect on char_code; the leader_id port and FSM are still present.

Test Plan:
- Reset, then char_req with char_xy=8'h1F -> next cycle char_vld=1, char_code=7'h30; leader_id=0, bad_write=0.
- local_vld, board_id=1, local_points=24'h001234 -> lookups 8'h1C..8'h1F give "1234"; leader_id=1 three cycles after FSM entry.
- ext_vld_1 id=2 score 24'h005000 together with ext_vld_2 id=2 score 24'h000007 -> player 2 = 005000, no bad_write; leader_id becomes 2.
- ext_vld_1 with id=4 (N_PLAYERS=3), then with digit nibble 4'hA -> bad_write pulses each time, scores unchanged, FSM stays IDLE.
- A write to player 3 = 24'h009999 during an active scan -> rescan occurs; final leader_id=3. clear -> leader_id=0 after the scan.
- LEADER_MARK_EN defined, leader_id=3 -> char_xy=8'h38 gives 7'h2A; undefined -> 7'h20. char_xy=8'h5E with board_id=2 -> 7'h32.
